// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a baud-timed shift FSM.
// Bytes go out LSB first. Back-to-back frames reload straight from STOP, so there is no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low) for one bit time
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (line high); reloads directly into START if a byte is waiting
module uart_buffered_tx #(
    parameter int BAUD_DIV = 2083,
    parameter int FIFO_AW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             wr,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] level,
    output logic             overflow,
    output logic             tx,
    output logic             busy
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]    CNT_MAX  = CW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_nx;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  shift;
    logic [7:0]  shift_nx;
    logic [2:0]  bitcnt;
    logic [2:0]  bitcnt_nx;
    logic        tx_nx;
    logic        busy_nx;
    logic        load;
    logic [CW-1:0] cnt;
    logic        bit_end;

    // full is the pre-edge value, so a pop in the same cycle never frees room for the write
    assign push    = wr && !full;
    assign pop     = load;
    assign head    = mem[rd_ptr];
    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_comb begin
        level_nx = level;
        if (push && !pop) begin
            level_nx = level + 1'b1;
        end else if (!push && pop) begin
            level_nx = level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_nx;
            full     <= (level_nx == LVL_FULL);
            empty    <= (level_nx == '0);
            overflow <= wr && full;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shift  <= '0;
            bitcnt <= '0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            shift  <= shift_nx;
            bitcnt <= bitcnt_nx;
            tx     <= tx_nx;
            busy   <= busy_nx;
            if (state == IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        shift_nx  = shift;
        bitcnt_nx = bitcnt;
        tx_nx     = tx;
        busy_nx   = busy;
        load      = 1'b0;
        case (state)
            IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                if (!empty) begin
                    load     = 1'b1;
                    shift_nx = head;
                    tx_nx    = 1'b0;
                    busy_nx  = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nx     = shift[0];
                    bitcnt_nx = 3'd0;
                    state_nx  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bitcnt == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = STOP;
                    end else begin
                        shift_nx  = {1'b0, shift[7:1]};
                        tx_nx     = shift[1];
                        bitcnt_nx = bitcnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        load     = 1'b1;
                        shift_nx = head;
                        tx_nx    = 1'b0;
                        busy_nx  = 1'b1;
                        state_nx = START;
                    end else begin
                        tx_nx    = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Directed bench for uart_buffered_tx at BAUD_DIV=4, FIFO_AW=2.
// A line monitor decodes every frame on tx independently of the stimulus.
module tb_uart_buffered_tx;

    localparam int BAUD = 4;
    localparam int AW   = 2;

    typedef struct {
        logic        wr;
        logic [7:0]  data;
        logic [AW:0] level;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        tx;
        logic        busy;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [7:0]  data;
    logic        wr;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        overflow;
    logic        tx;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_buffered_tx #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .data(data),
        .wr(wr),
        .full(full),
        .empty(empty),
        .level(level),
        .overflow(overflow),
        .tx(tx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 2000; k++) begin
            tick();
            if (!busy && empty) break;
        end
        if (k >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout waiting for idle, busy=%0b empty=%0b", name, busy, empty);
        end
    endtask

    task automatic check_rx(input string name);
        chk({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Line monitor: a frame starts on a low line, each bit must be constant for BAUD samples
    logic       mon_on = 1'b0;
    int         mon_idx = 0;
    logic       mon_bad = 1'b0;
    logic       mon_first = 1'b1;
    logic [7:0] mon_byte = 8'h00;

    initial begin
        int bit_i;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b1) begin
                mon_on = 1'b0;
            end else begin
                if (!mon_on) begin
                    if (tx === 1'b0) begin
                        mon_on  = 1'b1;
                        mon_idx = 0;
                        mon_bad = 1'b0;
                    end
                end else begin
                    mon_idx++;
                end
                if (mon_on) begin
                    bit_i = mon_idx / BAUD;
                    if (mon_idx % BAUD == 0) begin
                        mon_first = tx;
                        if (bit_i == 0 && tx !== 1'b0) mon_bad = 1'b1;
                        if (bit_i == 9 && tx !== 1'b1) mon_bad = 1'b1;
                        if (bit_i >= 1 && bit_i <= 8) mon_byte[bit_i-1] = tx;
                    end else if (tx !== mon_first) begin
                        mon_bad = 1'b1;
                    end
                    if (mon_idx == 10 * BAUD - 1) begin
                        n_cmp++;
                        if (mon_bad) begin
                            n_err++;
                            $display("FAIL frame_shape: byte %0h had a bad start/stop or unstable bit at %0t", mon_byte, $time);
                        end
                        rx_q.push_back(mon_byte);
                        mon_on = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   k;
        int   busy_run;

        // Overflow sequence: 0x11 starts a frame, 0x22..0x55 fill the FIFO, 0x66 is dropped
        vecs[0] = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h33, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h44, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h55, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h66, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b0;
        wr    = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        reset = 1'b1;
        tick();
        tick();

        // Single byte 0xA5
        rx_q.delete();
        data = 8'hA5;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
        data = 8'h00;
        chk("t1_push_level", level, 3'd1);
        chk("t1_push_tx", tx, 1'b1);
        chk("t1_push_empty", empty, 1'b0);
        tick();
        chk("t1_load_empty", empty, 1'b1);
        chk("t1_load_level", level, 3'd0);
        for (int i = 0; i < 10 * BAUD; i++) begin
            chk($sformatf("t1_tx_c%0d", i), tx, frame_bit(8'hA5, i / BAUD));
            chk($sformatf("t1_busy_c%0d", i), busy, 1'b1);
            tick();
        end
        chk("t1_end_busy", busy, 1'b0);
        chk("t1_end_tx", tx, 1'b1);
        chk("t1_end_empty", empty, 1'b1);
        exp_q = '{8'hA5};
        check_rx("t1_rx");

        // Back-to-back 0x00, 0xFF, 0x55
        rx_q.delete();
        wr   = 1'b1;
        data = 8'h00;
        tick();
        data = 8'hFF;
        tick();
        chk("t2_busy_start", busy, 1'b1);
        data = 8'h55;
        tick();
        wr   = 1'b0;
        chk("t2_level_peak", level, 3'd2);
        busy_run = busy ? 2 : 1;
        for (k = 1; k < 400; ) begin
            tick();
            k++;
            if (k == 39) chk("t2_level_pre_pop", level, 3'd2);
            if (k == 40) chk("t2_level_pop1", level, 3'd1);
            if (k == 80) chk("t2_level_pop2", level, 3'd0);
            if (busy) busy_run++;
            else break;
        end
        if (k >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL t2_timeout: busy still %0b after %0d cycles", busy, k);
        end
        chk("t2_busy_run", busy_run, 120);
        exp_q = '{8'h00, 8'hFF, 8'h55};
        check_rx("t2_rx");

        // Overflow: table-driven fill, then a write while full on the pop edge
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            wr   = vecs[i].wr;
            data = vecs[i].data;
            tick();
            chk($sformatf("t3_v%0d_level", i), level, vecs[i].level);
            chk($sformatf("t3_v%0d_empty", i), empty, vecs[i].empty);
            chk($sformatf("t3_v%0d_full", i), full, vecs[i].full);
            chk($sformatf("t3_v%0d_ovf", i), overflow, vecs[i].ovf);
            chk($sformatf("t3_v%0d_tx", i), tx, vecs[i].tx);
            chk($sformatf("t3_v%0d_busy", i), busy, vecs[i].busy);
        end
        wr = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        chk("t3_prepop_level", level, 3'd4);
        chk("t3_prepop_tx", tx, 1'b1);
        wr   = 1'b1;
        data = 8'h77;
        tick();
        wr   = 1'b0;
        chk("t3_pop_level", level, 3'd3);
        chk("t3_pop_full", full, 1'b0);
        chk("t3_pop_ovf", overflow, 1'b1);
        chk("t3_pop_tx", tx, 1'b0);
        tick();
        chk("t3_ovf_clear", overflow, 1'b0);
        wait_done("t3");
        chk("t3_level_end", level, 3'd0);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_rx("t3_rx");

        // Write coinciding with the STOP->START pop at level 2
        rx_q.delete();
        wr   = 1'b1;
        data = 8'h81;
        tick();
        data = 8'h42;
        tick();
        data = 8'hC3;
        tick();
        wr   = 1'b0;
        for (int i = 0; i < 38; i++) tick();
        chk("t4_level_before", level, 3'd2);
        wr   = 1'b1;
        data = 8'h24;
        tick();
        wr   = 1'b0;
        data = 8'h00;
        chk("t4_level_same", level, 3'd2);
        chk("t4_tx_start", tx, 1'b0);
        chk("t4_busy", busy, 1'b1);
        wait_done("t4");
        exp_q = '{8'h81, 8'h42, 8'hC3, 8'h24};
        check_rx("t4_rx");

        // Reset during DATA bit 3, then a clean 0x3C frame
        rx_q.delete();
        wr   = 1'b1;
        data = 8'h00;
        tick();
        data = 8'h77;
        tick();
        wr   = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("t5_pre_tx", tx, 1'b0);
        chk("t5_pre_empty", empty, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_tx", tx, 1'b1);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_empty", empty, 1'b1);
        chk("t5_async_level", level, 3'd0);
        tick();
        tick();
        chk("t5_hold_tx", tx, 1'b1);
        rx_q.delete();
        reset = 1'b1;
        tick();
        wr   = 1'b1;
        data = 8'h3C;
        tick();
        wr   = 1'b0;
        data = 8'hFF;
        wait_done("t5");
        exp_q = '{8'h3C};
        check_rx("t5_rx");

        // Ten single bytes across pointer wrap
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            wr   = 1'b1;
            data = 8'(i);
            exp_q.push_back(8'(i));
            tick();
            wr = 1'b0;
            wait_done("t6");
        end
        chk("t6_level_end", level, 3'd0);
        chk("t6_empty_end", empty, 1'b1);
        check_rx("t6_rx");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
